// File: rtl/demux1x16_deserializer.sv
// demux1x16_deserializer: steers a serial bit stream into 16 slots and
// presents each completed 16-bit word in parallel on `out`.
// The optional macro DEMUX1X16_MSB_FIRST_EN maps slot k to out[15-k], so the
// first bit received is the MSB. By default slot k maps to out[k], so the
// first bit received is the LSB.
module demux1x16_deserializer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in,
  input  logic        in_valid,
  input  logic        start,
  output logic [3:0]  sel,
  output logic        busy,
  output logic [15:0] out,
  output logic        out_valid
);

  typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [3:0]  sel_nxt;
  logic [15:0] shadow, shadow_nxt;
  logic [15:0] out_nxt;
  logic        out_valid_nxt;
  logic [15:0] word;

  // Bit position within the word that a given slot occupies.
  function automatic logic [3:0] bit_pos(input logic [3:0] slot);
`ifdef DEMUX1X16_MSB_FIRST_EN
    return 4'd15 - slot;
`else
    return slot;
`endif
  endfunction

  // Returns `base` with `b` written into the position of `slot`.
  function automatic logic [15:0] insert_bit(input logic [15:0] base,
                                             input logic [3:0]  slot,
                                             input logic        b);
    logic [15:0] w;
    w = base;
    w[bit_pos(slot)] = b;
    return w;
  endfunction

  // busy is a direct decode of the registered state bit.
  assign busy = (state == COLLECT);

  // Next-state, slot counter, shadow word and output word decisions.
  always_comb begin
    state_nxt     = state;
    sel_nxt       = sel;
    shadow_nxt    = shadow;
    out_nxt       = out;
    out_valid_nxt = 1'b0;
    word          = insert_bit(shadow, sel, in);
    if (start) begin
      // Begin or realign: the partial word is discarded; a bit presented
      // together with start is the first bit of the new word.
      state_nxt = COLLECT;
      if (in_valid) begin
        shadow_nxt = insert_bit(16'h0000, 4'd0, in);
        sel_nxt    = 4'd1;
      end else begin
        shadow_nxt = 16'h0000;
        sel_nxt    = 4'd0;
      end
    end else if (state == COLLECT && in_valid) begin
      if (sel == 4'd15) begin
        // Last slot: publish the whole word and start a fresh one.
        out_nxt       = word;
        out_valid_nxt = 1'b1;
        shadow_nxt    = 16'h0000;
        sel_nxt       = 4'd0;
      end else begin
        shadow_nxt = word;
        sel_nxt    = sel + 4'd1;
      end
    end
  end

  // State, counter, shadow and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 4'd0;
      shadow    <= 16'h0000;
      out       <= 16'h0000;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      shadow    <= shadow_nxt;
      out       <= out_nxt;
      out_valid <= out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_demux1x16_deserializer.sv
// Scoreboard bench for demux1x16_deserializer: the stimulus pushes the
// expected word and the cycle its pulse must appear; a monitor pops on
// every out_valid pulse and compares word and arrival cycle.
module tb_demux1x16_deserializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in;
  logic        in_valid;
  logic        start;
  logic [3:0]  sel;
  logic        busy;
  logic [15:0] out;
  logic        out_valid;

`ifdef DEMUX1X16_MSB_FIRST_EN
  localparam logic [15:0] E_LSBSEQ_3F0A = 16'h50FC;
  localparam logic [15:0] E_MSBSEQ_3F0A = 16'h3F0A;
  localparam logic [15:0] E_LSBSEQ_00C5 = 16'hA300;
`else
  localparam logic [15:0] E_LSBSEQ_3F0A = 16'h3F0A;
  localparam logic [15:0] E_MSBSEQ_3F0A = 16'h50FC;
  localparam logic [15:0] E_LSBSEQ_00C5 = 16'h00C5;
`endif

  typedef struct {
    logic [15:0] w;
    int          c;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  demux1x16_deserializer dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .in_valid  (in_valid),
    .start     (start),
    .sel       (sel),
    .busy      (busy),
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [15:0] w, input int c);
    exp_t e;
    e.w = w;
    e.c = c;
    q.push_back(e);
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out_word", {16'h0, out}, {16'h0, e.w});
        check("pulse_cycle", cyc, e.c);
      end
    end
  end

  task automatic idle();
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; in = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; in = 1'b0;
  endtask

  task automatic send(input logic b);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in = b;
  endtask

  task automatic send_lsb(input logic [15:0] w);
    for (int i = 0; i < 16; i++) send(w[i]);
  endtask

  task automatic send_msb(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send(w[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    logic [15:0] w;
    rst = 1'b1; in = 1'b0; in_valid = 1'b0; start = 1'b0;
    #12;
    check("reset_sel", {28'h0, sel}, 32'd0);
    check("reset_busy", {31'h0, busy}, 32'd0);
    check("reset_out", {16'h0, out}, 32'd0);
    check("reset_out_valid", {31'h0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // IDLE ignores in_valid.
    for (int i = 0; i < 3; i++) send(1'b1);
    idle();
    check("idle_ignores_sel", {28'h0, sel}, 32'd0);
    check("idle_busy", {31'h0, busy}, 32'd0);

    // Continuous word.
    do_start();
    s = cyc;
    push(E_LSBSEQ_3F0A, s + 17);
    send_lsb(16'h3F0A);
    idle();
    check("cont_sel_wrap", {28'h0, sel}, 32'd0);
    check("cont_busy", {31'h0, busy}, 32'd1);
    repeat (3) idle();
    check("out_held", {16'h0, out}, {16'h0, E_LSBSEQ_3F0A});

    // Same word with 3-cycle gaps after bits 5 and 11.
    do_start();
    s = cyc;
    push(E_LSBSEQ_3F0A, s + 23);
    w = 16'h3F0A;
    for (int i = 0; i < 16; i++) begin
      send(w[i]);
      if (i == 5 || i == 11) begin
        for (int g = 0; g < 3; g++) begin
          idle();
          check((i == 5) ? "gap_sel_6" : "gap_sel_12", {28'h0, sel}, (i == 5) ? 32'd6 : 32'd12);
        end
      end
    end
    repeat (2) idle();

    // Back-to-back words, no second start.
    do_start();
    s = cyc;
    push(E_LSBSEQ_3F0A, s + 17);
    push(16'hFFFF, s + 33);
    send_lsb(16'h3F0A);
    send_lsb(16'hFFFF);
    repeat (2) idle();
    check("b2b_out", {16'h0, out}, 32'h0000FFFF);

    // Realign after 7 bits of ones: partial word is dropped.
    do_start();
    for (int i = 0; i < 7; i++) send(1'b1);
    do_start();
    s = cyc;
    push(E_LSBSEQ_00C5, s + 17);
    send_lsb(16'h00C5);
    repeat (2) idle();

    // start together with the first bit.
    w = 16'h3F0A;
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; in = w[0];
    s = cyc;
    push(E_LSBSEQ_3F0A, s + 16);
    for (int i = 1; i < 16; i++) send(w[i]);
    idle();
    check("start_bit_sel", {28'h0, sel}, 32'd0);

    // MSB-first ordering of the same value.
    do_start();
    s = cyc;
    push(E_MSBSEQ_3F0A, s + 17);
    send_msb(16'h3F0A);
    repeat (2) idle();

    // Asynchronous reset after 9 bits.
    do_start();
    for (int i = 0; i < 9; i++) send(1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("arst_out", {16'h0, out}, 32'd0);
    check("arst_out_valid", {31'h0, out_valid}, 32'd0);
    check("arst_sel", {28'h0, sel}, 32'd0);
    check("arst_busy", {31'h0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send_lsb(16'hFFFF);
    idle();
    check("post_rst_sel", {28'h0, sel}, 32'd0);
    check("post_rst_busy", {31'h0, busy}, 32'd0);
    check("post_rst_out", {16'h0, out}, 32'd0);
    repeat (2) idle();

    check("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
